clock_ctrl: RTL and testbench

CLOCK_CTRL -- requirements
Module: clock_ctrl

---
 rtl/clock_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_clock_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// clock_ctrl: set-mode FSM plus alarm FSM for a 24-hour alarm clock.
// Define CLOCK_CTRL_SNOOZE_EN to build the SNOOZE state and snooze counter.
module clock_ctrl #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int SET_TIMEOUT = 10,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_alarm,
    input  logic       btn_snooze,
    input  logic [4:0] cur_h,
    input  logic [5:0] cur_m,
    input  logic [5:0] cur_s,
    input  logic [4:0] alm_h,
    input  logic [5:0] alm_m,
    output logic       inc_h,
    output logic       inc_m,
    output logic       alm_inc_h,
    output logic       alm_inc_m,
    output logic [2:0] mode,
    output logic       disp_alarm,
    output logic       alarm_armed,
    output logic       ring,
    output logic [1:0] snooze_cnt
);

    localparam int MAX_A = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int MAX_P = (MAX_A > SET_TIMEOUT) ? MAX_A : SET_TIMEOUT;
    localparam int CNT_W = $clog2(MAX_P + 1);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(SET_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SECS - 1);
    // The snooze limit is clamped to what the 2-bit snooze_cnt can show.
    localparam int               SNZ_LIMIT = (MAX_SNOOZE > 3) ? 3 : MAX_SNOOZE;
    localparam logic [1:0]       SNZ_MAX   = 2'(SNZ_LIMIT);

    localparam int E_MODE   = 0;
    localparam int E_INC    = 1;
    localparam int E_ALARM  = 2;
    localparam int E_SNOOZE = 3;

    typedef enum logic [2:0] {
        S_RUN    = 3'd0,
        S_SET_H  = 3'd1,
        S_SET_M  = 3'd2,
        S_SET_AH = 3'd3,
        S_SET_AM = 3'd4
    } set_state_t;

`ifdef CLOCK_CTRL_SNOOZE_EN
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECS - 1);
    typedef enum logic [1:0] {
        A_IDLE   = 2'd0,
        A_RING   = 2'd1,
        A_SNOOZE = 2'd2
    } alarm_state_t;
`else
    typedef enum logic [1:0] {
        A_IDLE = 2'd0,
        A_RING = 2'd1
    } alarm_state_t;
`endif

    logic [3:0]       btn_vec;
    logic [3:0]       btn_reg;
    logic [3:0]       btn_edge;
    logic             live_reg;

    set_state_t       set_reg, set_next;
    logic [CNT_W-1:0] idle_reg, idle_next;

    alarm_state_t     alarm_reg, alarm_next;
    logic [CNT_W-1:0] acnt_reg, acnt_next;
    logic             armed_reg, armed_next;
    logic [1:0]       snz_reg, snz_next;
    logic             trigger;

    logic             inc_h_reg, inc_m_reg, alm_inc_h_reg, alm_inc_m_reg;
    logic             disp_reg, ring_reg;

    assign btn_vec = {btn_snooze, btn_alarm, btn_inc, btn_mode};

    // live_reg masks edges for the first cycle after reset so that a button
    // held through reset release is absorbed into btn_reg without an event.
    for (genvar gi = 0; gi < 4; gi++) begin : g_edge
        assign btn_edge[gi] = btn_vec[gi] & ~btn_reg[gi] & live_reg;
    end

`ifndef CLOCK_CTRL_SNOOZE_EN
    logic unused_snooze;
    assign unused_snooze = btn_edge[E_SNOOZE] | (SNZ_MAX == 2'd0);
`endif

    // Set FSM: a mode edge always wins over a simultaneous idle timeout.
    always_comb begin
        set_next  = set_reg;
        idle_next = idle_reg;
        if (btn_edge[E_MODE]) begin
            idle_next = '0;
            case (set_reg)
                S_RUN:    set_next = S_SET_H;
                S_SET_H:  set_next = S_SET_M;
                S_SET_M:  set_next = S_SET_AH;
                S_SET_AH: set_next = S_SET_AM;
                default:  set_next = S_RUN;
            endcase
        end else if (set_reg != S_RUN) begin
            if (btn_edge[E_INC]) begin
                idle_next = '0;
            end else if (tick) begin
                if (idle_reg >= IDLE_LAST) begin
                    set_next  = S_RUN;
                    idle_next = '0;
                end else begin
                    idle_next = idle_reg + 1'b1;
                end
            end
        end
    end

    assign trigger = armed_reg & tick & (cur_h == alm_h) & (cur_m == alm_m) &
                     (cur_s == 6'd0);

    // Alarm FSM: dismiss has priority over snooze, snooze over the ring timeout.
    always_comb begin
        alarm_next = alarm_reg;
        acnt_next  = acnt_reg;
        armed_next = armed_reg;
        snz_next   = snz_reg;
        case (alarm_reg)
            A_IDLE: begin
                if (trigger) begin
                    alarm_next = A_RING;
                    acnt_next  = '0;
                    snz_next   = '0;
                end else if (btn_edge[E_ALARM] && (set_reg == S_RUN)) begin
                    armed_next = ~armed_reg;
                end
            end
            A_RING: begin
                if (btn_edge[E_ALARM]) begin
                    alarm_next = A_IDLE;
                    acnt_next  = '0;
`ifdef CLOCK_CTRL_SNOOZE_EN
                end else if (btn_edge[E_SNOOZE] && (snz_reg < SNZ_MAX)) begin
                    alarm_next = A_SNOOZE;
                    acnt_next  = '0;
                    snz_next   = snz_reg + 1'b1;
`endif
                end else if (tick) begin
                    if (acnt_reg >= RING_LAST) begin
                        alarm_next = A_IDLE;
                        acnt_next  = '0;
                    end else begin
                        acnt_next = acnt_reg + 1'b1;
                    end
                end
            end
`ifdef CLOCK_CTRL_SNOOZE_EN
            A_SNOOZE: begin
                if (btn_edge[E_ALARM]) begin
                    alarm_next = A_IDLE;
                    acnt_next  = '0;
                end else if (tick) begin
                    if (acnt_reg >= SNOOZE_LAST) begin
                        alarm_next = A_RING;
                        acnt_next  = '0;
                    end else begin
                        acnt_next = acnt_reg + 1'b1;
                    end
                end
            end
`endif
            default: begin
                alarm_next = A_IDLE;
                acnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_reg      <= 1'b0;
            btn_reg       <= '0;
            set_reg       <= S_RUN;
            idle_reg      <= '0;
            alarm_reg     <= A_IDLE;
            acnt_reg      <= '0;
            armed_reg     <= 1'b0;
            snz_reg       <= '0;
            inc_h_reg     <= 1'b0;
            inc_m_reg     <= 1'b0;
            alm_inc_h_reg <= 1'b0;
            alm_inc_m_reg <= 1'b0;
            disp_reg      <= 1'b0;
            ring_reg      <= 1'b0;
        end else begin
            live_reg      <= 1'b1;
            btn_reg       <= btn_vec;
            set_reg       <= set_next;
            idle_reg      <= idle_next;
            alarm_reg     <= alarm_next;
            acnt_reg      <= acnt_next;
            armed_reg     <= armed_next;
            snz_reg       <= snz_next;
            inc_h_reg     <= btn_edge[E_INC] && (set_reg == S_SET_H);
            inc_m_reg     <= btn_edge[E_INC] && (set_reg == S_SET_M);
            alm_inc_h_reg <= btn_edge[E_INC] && (set_reg == S_SET_AH);
            alm_inc_m_reg <= btn_edge[E_INC] && (set_reg == S_SET_AM);
            disp_reg      <= (set_next == S_SET_AH) || (set_next == S_SET_AM);
            ring_reg      <= (alarm_next == A_RING);
        end
    end

    assign inc_h       = inc_h_reg;
    assign inc_m       = inc_m_reg;
    assign alm_inc_h   = alm_inc_h_reg;
    assign alm_inc_m   = alm_inc_m_reg;
    assign mode        = set_reg;
    assign disp_alarm  = disp_reg;
    assign alarm_armed = armed_reg;
    assign ring        = ring_reg;
    assign snooze_cnt  = snz_reg;

endmodule

// File: tb/tb_clock_ctrl.sv
// Testbench for clock_ctrl: table-driven set-mode vectors, directed alarm
// sequences and a randomized run checked against a reference model.
`timescale 1ns/1ps
module tb_clock_ctrl;

    localparam int RING_SECS   = 60;
    localparam int SNOOZE_SECS = 300;
    localparam int SET_TIMEOUT = 10;
    localparam int MAX_SNOOZE  = 3;
`ifdef CLOCK_CTRL_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, tick, btn_mode, btn_inc, btn_alarm, btn_snooze;
    logic [4:0] cur_h, alm_h;
    logic [5:0] cur_m, cur_s, alm_m;
    logic       inc_h, inc_m, alm_inc_h, alm_inc_m, disp_alarm, alarm_armed, ring;
    logic [2:0] mode;
    logic [1:0] snooze_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int c_ih = 0, c_im = 0, c_aih = 0, c_aim = 0;

    always #5 clk = ~clk;

    clock_ctrl #(
        .RING_SECS(RING_SECS), .SNOOZE_SECS(SNOOZE_SECS),
        .SET_TIMEOUT(SET_TIMEOUT), .MAX_SNOOZE(MAX_SNOOZE)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_alarm(btn_alarm),
        .btn_snooze(btn_snooze),
        .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s), .alm_h(alm_h), .alm_m(alm_m),
        .inc_h(inc_h), .inc_m(inc_m), .alm_inc_h(alm_inc_h), .alm_inc_m(alm_inc_m),
        .mode(mode), .disp_alarm(disp_alarm), .alarm_armed(alarm_armed),
        .ring(ring), .snooze_cnt(snooze_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (rules-level, one step per clk) -------
    int m_mode, m_idle, m_ast, m_acnt, m_sc;   // m_ast: 0 idle, 1 ring, 2 snooze
    bit m_armed, m_live;
    bit [3:0] m_prev;
    bit m_ih, m_im, m_aih, m_aim;

    task automatic m_reset();
        m_mode = 0; m_idle = 0; m_ast = 0; m_acnt = 0; m_sc = 0;
        m_armed = 0; m_live = 0; m_prev = '0;
        m_ih = 0; m_im = 0; m_aih = 0; m_aim = 0;
    endtask

    task automatic m_step();
        bit [3:0] now, e;
        int old_mode;
        now = {btn_snooze, btn_alarm, btn_inc, btn_mode};
        e = m_live ? (now & ~m_prev) : 4'b0000;
        m_prev = now;
        m_live = 1;
        old_mode = m_mode;
        m_ih  = e[1] && old_mode == 1;
        m_im  = e[1] && old_mode == 2;
        m_aih = e[1] && old_mode == 3;
        m_aim = e[1] && old_mode == 4;
        if (e[0]) begin
            m_mode = (m_mode + 1) % 5;
            m_idle = 0;
        end else if (m_mode != 0) begin
            if (e[1]) m_idle = 0;
            else if (tick) begin
                m_idle++;
                if (m_idle >= SET_TIMEOUT) begin m_mode = 0; m_idle = 0; end
            end
        end
        case (m_ast)
            0: if (m_armed && tick && cur_h == alm_h && cur_m == alm_m && cur_s == 0) begin
                   m_ast = 1; m_acnt = 0; m_sc = 0;
               end else if (e[2] && old_mode == 0) m_armed = !m_armed;
            1: if (e[2]) m_ast = 0;
               else if (SNZ_EN && e[3] && m_sc < MAX_SNOOZE) begin
                   m_ast = 2; m_sc++; m_acnt = 0;
               end else if (tick) begin
                   m_acnt++;
                   if (m_acnt >= RING_SECS) m_ast = 0;
               end
            default: if (e[2]) m_ast = 0;
               else if (tick) begin
                   m_acnt++;
                   if (m_acnt >= SNOOZE_SECS) begin m_ast = 1; m_acnt = 0; end
               end
        endcase
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    // Negedge monitor: pulse counting plus model comparison every cycle.
    initial forever begin
        @(negedge clk);
        if (inc_h) c_ih++;
        if (inc_m) c_im++;
        if (alm_inc_h) c_aih++;
        if (alm_inc_m) c_aim++;
        if (chk_en) begin
            check("mdl_mode", int'(mode), m_mode);
            check("mdl_disp", int'(disp_alarm), int'(m_mode == 3 || m_mode == 4));
            check("mdl_armed", int'(alarm_armed), int'(m_armed));
            check("mdl_ring", int'(ring), int'(m_ast == 1));
            check("mdl_snooze_cnt", int'(snooze_cnt), m_sc);
            check("mdl_inc_h", int'(inc_h), int'(m_ih));
            check("mdl_inc_m", int'(inc_m), int'(m_im));
            check("mdl_alm_inc_h", int'(alm_inc_h), int'(m_aih));
            check("mdl_alm_inc_m", int'(alm_inc_m), int'(m_aim));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_mode = v;
            1: btn_inc = v;
            2: btn_alarm = v;
            default: btn_snooze = v;
        endcase
    endtask

    task automatic press(input int b);
        @(negedge clk); set_btn(b, 1'b1);
        @(negedge clk); set_btn(b, 1'b0);
    endtask

    task automatic press_two(input int a, input int b);
        @(negedge clk); set_btn(a, 1'b1); set_btn(b, 1'b1);
        @(negedge clk); set_btn(a, 1'b0); set_btn(b, 1'b0);
    endtask

    task automatic do_tick(input int n);
        repeat (n) begin
            @(negedge clk); tick = 1'b1;
            @(negedge clk); tick = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        c_ih = 0; c_im = 0; c_aih = 0; c_aim = 0;
    endtask

    task automatic start_ring();
        cur_h = 5'd7; cur_m = 6'd30; cur_s = 6'd0;
        do_tick(1);
        cur_s = 6'd1;
    endtask

    typedef struct {
        int n_mode; int n_inc;
        int e_mode; int e_disp; int e_ih; int e_im; int e_aih; int e_aim;
    } vec_t;
    vec_t vecs[6];

    initial begin
        vecs[0] = '{2, 3, 2, 0, 0, 3, 0, 0};
        vecs[1] = '{1, 2, 1, 0, 2, 0, 0, 0};
        vecs[2] = '{3, 1, 3, 1, 0, 0, 1, 0};
        vecs[3] = '{4, 2, 4, 1, 0, 0, 0, 2};
        vecs[4] = '{0, 2, 0, 0, 0, 0, 0, 0};
        vecs[5] = '{5, 1, 0, 0, 0, 0, 0, 0};

        rst = 1'b1; tick = 0; btn_mode = 0; btn_inc = 0; btn_alarm = 0; btn_snooze = 0;
        alm_h = 5'd7; alm_m = 6'd30; cur_h = 5'd0; cur_m = 6'd0; cur_s = 6'd1;
        repeat (3) @(negedge clk);
        check("rst_mode", int'(mode), 0);
        check("rst_ring", int'(ring), 0);
        check("rst_armed", int'(alarm_armed), 0);
        check("rst_disp", int'(disp_alarm), 0);
        check("rst_snooze_cnt", int'(snooze_cnt), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        $display("txn reset: mode=%0d ring=%0d armed=%0d", mode, ring, alarm_armed);

        // Set-mode navigation and increment routing.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            repeat (vecs[i].n_mode) press(0);
            repeat (vecs[i].n_inc) press(1);
            @(negedge clk);
            check("vec_mode", int'(mode), vecs[i].e_mode);
            check("vec_disp", int'(disp_alarm), vecs[i].e_disp);
            check("vec_inc_h", c_ih, vecs[i].e_ih);
            check("vec_inc_m", c_im, vecs[i].e_im);
            check("vec_alm_inc_h", c_aih, vecs[i].e_aih);
            check("vec_alm_inc_m", c_aim, vecs[i].e_aim);
            $display("txn vec %0d: modes=%0d incs=%0d -> mode=%0d pulses h/m/ah/am=%0d/%0d/%0d/%0d",
                     i, vecs[i].n_mode, vecs[i].n_inc, mode, c_ih, c_im, c_aih, c_aim);
        end

        // Idle timeout from SET_AH.
        do_reset();
        repeat (3) press(0);
        check("to_disp_before", int'(disp_alarm), 1);
        do_tick(SET_TIMEOUT - 1);
        check("to_mode_9", int'(mode), 3);
        do_tick(1);
        check("to_mode_10", int'(mode), 0);
        check("to_disp_after", int'(disp_alarm), 0);
        $display("txn timeout: mode=%0d disp=%0d", mode, disp_alarm);

        // Mode edge coinciding with the timeout tick: mode edge wins.
        do_reset();
        press(0);
        do_tick(SET_TIMEOUT - 1);
        @(negedge clk); tick = 1'b1; btn_mode = 1'b1;
        @(negedge clk); tick = 1'b0; btn_mode = 1'b0;
        check("race_mode", int'(mode), 2);
        $display("txn mode+timeout: mode=%0d", mode);

        // Arm, ring, auto-stop after RING_SECS ticks.
        do_reset();
        cur_h = 5'd7; cur_m = 6'd30; cur_s = 6'd1;
        press(2);
        check("arm", int'(alarm_armed), 1);
        start_ring();
        check("ring_start", int'(ring), 1);
        do_tick(RING_SECS - 1);
        check("ring_59", int'(ring), 1);
        do_tick(1);
        check("ring_60", int'(ring), 0);
        check("ring_armed", int'(alarm_armed), 1);
        $display("txn ring timeout: ring=%0d armed=%0d", ring, alarm_armed);

        // Simultaneous dismiss and snooze resolve as dismiss.
        start_ring();
        press_two(2, 3);
        check("dual_ring", int'(ring), 0);
        check("dual_armed", int'(alarm_armed), 1);
        do_tick(SNOOZE_SECS + 2);
        check("dual_no_rering", int'(ring), 0);
        $display("txn dismiss+snooze: ring=%0d armed=%0d", ring, alarm_armed);

        // Snooze limit (or snooze ignored when the feature is absent).
        start_ring();
        if (SNZ_EN) begin
            for (int i = 1; i <= MAX_SNOOZE; i++) begin
                press(3);
                check("snz_cnt", int'(snooze_cnt), i);
                check("snz_ring_off", int'(ring), 0);
                do_tick(SNOOZE_SECS - 1);
                check("snz_still_off", int'(ring), 0);
                do_tick(1);
                check("snz_rering", int'(ring), 1);
                $display("txn snooze %0d: cnt=%0d ring=%0d", i, snooze_cnt, ring);
            end
        end
        press(3);
        check("snz_limit_ring", int'(ring), 1);
        check("snz_limit_cnt", int'(snooze_cnt), SNZ_EN ? MAX_SNOOZE : 0);
        press(2);
        check("snz_dismiss", int'(ring), 0);
        $display("txn snooze limit: cnt=%0d ring=%0d", snooze_cnt, ring);

        // Asynchronous reset drops ring without a clock edge.
        start_ring();
        check("async_pre_ring", int'(ring), 1);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        check("async_ring", int'(ring), 0);
        check("async_armed", int'(alarm_armed), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        $display("txn async reset: ring=%0d", ring);

        // Buttons held through reset release produce no events.
        @(negedge clk); #2 rst = 1'b1;
        @(negedge clk); btn_inc = 1'b1; btn_mode = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        c_ih = 0; c_im = 0; c_aih = 0; c_aim = 0;
        repeat (50) @(negedge clk);
        check("hold_mode", int'(mode), 0);
        check("hold_pulses", c_ih + c_im + c_aih + c_aim, 0);
        btn_inc = 1'b0; btn_mode = 1'b0;
        $display("txn held buttons: mode=%0d pulses=%0d", mode, c_ih + c_im + c_aih + c_aim);

        // Randomized run against the reference model.
        do_reset();
        for (int blk = 0; blk < 40; blk++) begin
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                btn_mode   = ($urandom_range(0, 39) == 0);
                btn_inc    = ($urandom_range(0, 5) == 0);
                btn_alarm  = ($urandom_range(0, 29) == 0);
                btn_snooze = ($urandom_range(0, 9) == 0);
                tick       = ($urandom_range(0, 1) == 0);
                cur_h      = ($urandom_range(0, 1) == 0) ? 5'd7 : 5'(($urandom_range(0, 22) + 8) % 24);
                cur_m      = ($urandom_range(0, 3) != 0) ? 6'd30 : 6'($urandom_range(0, 29));
                cur_s      = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(1, 59));
            end
            $display("txn random block %0d: mode=%0d armed=%0d ring=%0d snz=%0d",
                     blk, mode, alarm_armed, ring, snooze_cnt);
        end
        @(negedge clk);
        tick = 0; btn_mode = 0; btn_inc = 0; btn_alarm = 0; btn_snooze = 0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
